// File: rtl/cnn_pkg.sv
// Shared stage encodings and widths for the CNN layer sequencer.
package cnn_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    SEQ_IDLE = 3'd0,
    SEQ_CONV = 3'd1,
    SEQ_POOL = 3'd2,
    SEQ_FC   = 3'd3,
    SEQ_LOSS = 3'd4,
    SEQ_DONE = 3'd5,
    SEQ_ERR  = 3'd7
  } seq_state_t;

  function automatic logic is_engine_stage(input seq_state_t s);
    return (s == SEQ_CONV) || (s == SEQ_POOL) || (s == SEQ_FC) || (s == SEQ_LOSS);
  endfunction

  function automatic logic is_busy_state(input seq_state_t s);
    return is_engine_stage(s) || (s == SEQ_DONE);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-stage watchdog: counts active cycles from each start-pulse cycle (value 0 there)
// and flags the cycle in which the count reaches TIMEOUT_CYCLES-1.
module seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  input  logic active_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // restart_i arrives one cycle ahead so the start-pulse cycle already reads zero
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (active_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = active_i && (cnt_q == LIMIT);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Sequences CONV -> POOL -> FC -> (LOSS) engines with one-cycle start pulses and registered status.
// Optional per-stage watchdog and sticky error when SEQ_TIMEOUT_EN is defined.
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               train_mode,
  input  logic               abort,
  input  logic               conv_done,
  input  logic               pool_done,
  input  logic               fc_done,
  input  logic               loss_done,
  output logic               conv_start,
  output logic               pool_start,
  output logic               fc_start,
  output logic               loss_start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [STAGE_W-1:0] stage,
  output logic [CNT_W-1:0]   cycle_count
);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic             train_q;
  logic             conv_start_q;
  logic             pool_start_q;
  logic             fc_start_q;
  logic             loss_start_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stage_done;
  logic             run_accept;
  logic             enter_stage;
  logic             wd_expire;

  always_comb begin
    stage_done = 1'b0;
    case (state_q)
      SEQ_CONV: stage_done = conv_done;
      SEQ_POOL: stage_done = pool_done;
      SEQ_FC:   stage_done = fc_done;
      SEQ_LOSS: stage_done = loss_done;
      default:  stage_done = 1'b0;
    endcase
  end

  assign run_accept = !abort && start && ((state_q == SEQ_IDLE) || (state_q == SEQ_ERR));

  // abort outranks everything; a done in the watchdog limit cycle beats the timeout
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = SEQ_IDLE;
    end else begin
      case (state_q)
        SEQ_IDLE, SEQ_ERR: if (start) state_d = SEQ_CONV;
        SEQ_CONV: begin
          if (stage_done)     state_d = SEQ_POOL;
          else if (wd_expire) state_d = SEQ_ERR;
        end
        SEQ_POOL: begin
          if (stage_done)     state_d = SEQ_FC;
          else if (wd_expire) state_d = SEQ_ERR;
        end
        SEQ_FC: begin
          if (stage_done)     state_d = train_q ? SEQ_LOSS : SEQ_DONE;
          else if (wd_expire) state_d = SEQ_ERR;
        end
        SEQ_LOSS: begin
          if (stage_done)     state_d = SEQ_DONE;
          else if (wd_expire) state_d = SEQ_ERR;
        end
        SEQ_DONE: state_d = SEQ_IDLE;
        default:  state_d = SEQ_IDLE;
      endcase
    end
  end

  assign enter_stage = is_engine_stage(state_d) && (state_d != state_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEQ_IDLE;
      train_q      <= 1'b0;
      conv_start_q <= 1'b0;
      pool_start_q <= 1'b0;
      fc_start_q   <= 1'b0;
      loss_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      conv_start_q <= enter_stage && (state_d == SEQ_CONV);
      pool_start_q <= enter_stage && (state_d == SEQ_POOL);
      fc_start_q   <= enter_stage && (state_d == SEQ_FC);
      loss_start_q <= enter_stage && (state_d == SEQ_LOSS);
      busy_q       <= is_busy_state(state_d);
      done_q       <= (state_d == SEQ_DONE);
      // the counter includes the cycle it is displayed in, so the first CONV cycle reads 1
      if (run_accept) begin
        train_q <= train_mode;
        cnt_q   <= CNT_W'(1);
      end else if (is_busy_state(state_d) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic error_q;

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .restart_i(enter_stage),
    .active_i (is_engine_stage(state_q)),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      error_q <= 1'b0;
    end else if (abort || run_accept) begin
      error_q <= 1'b0;
    end else if ((state_d == SEQ_ERR) && (state_q != SEQ_ERR)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign wd_expire = 1'b0;
  assign error     = 1'b0;
`endif

  assign conv_start  = conv_start_q;
  assign pool_start  = pool_start_q;
  assign fc_start    = fc_start_q;
  assign loss_start  = loss_start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign stage       = state_q;
  assign cycle_count = cnt_q;

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Top-level stage sequencer for the training/inference datapath. It issues one-cycle start pulses to the convolution, pooling, fully-connected and loss engines in order, and waits for each engine's done pulse before starting the next. It reports run status, the current stage and the total run cycle count, and it sits between the testbench/host `start`/`done` handshake and the layer engines.

## Interface
- `TIMEOUT_CYCLES`, 4096: per-stage watchdog limit in cycles; used only with `SEQ_TIMEOUT_EN`.
- `CNT_W`, 32: width of `cycle_count`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request; sampled in IDLE, DONE-exit or ERR.
- `train_mode` in 1: captured with `start`; 1 runs the LOSS stage, 0 skips it.
- `abort` in 1: synchronous return to IDLE.
- `conv_done`, `pool_done`, `fc_done`, `loss_done` in 1 each: engine completion pulses.
- `conv_start`, `pool_start`, `fc_start`, `loss_start` out 1 each: one-cycle engine start pulses.
- `busy` out 1: high in CONV, POOL, FC, LOSS and DONE.
- `done` out 1: one-cycle run-complete pulse.
- `error` out 1: sticky watchdog error.
- `stage` out 3: encoding is IDLE=0, CONV=1, POOL=2, FC=3, LOSS=4, DONE=5, ERR=7.
- `cycle_count` out `CNT_W`: cycles consumed by the last or current run.

## Operation
- States: IDLE, CONV, POOL, FC, LOSS, DONE, ERR. All outputs are registered.
- **Reset:** state=IDLE; all starts, `busy`, `done` and `error` are 0; `stage`=0; `cycle_count`=0.
- **Start:** in IDLE or ERR, `start`=1 moves to CONV next cycle.
  - `conv_start`=1 for that first CONV cycle only.
  - `train_mode` is latched, `cycle_count` is cleared, `error` is cleared.
  - `start` in any other state is ignored.
- **Stage advance:** the matching done in the current state moves to the next state next cycle, and that state's start pulses in its first cycle.
  - Order: CONV→POOL→FC→LOSS→DONE.
  - FC→DONE when the latched `train_mode`=0.
- A stage's done is accepted in any cycle of that state, including the start-pulse cycle.
- Done inputs belonging to other stages, and any done in IDLE, DONE or ERR, are ignored with no side effect.
- **DONE:** lasts exactly one cycle with `done`=1, then IDLE. `start` is ignored during DONE.
- **Abort:** `abort`=1 in any state moves to IDLE next cycle.
  - All start pulses are suppressed from that edge.
  - `error` is cleared; `cycle_count` holds.
  - `abort` has priority over `start` and all done inputs.
- **Reset mid-run:** identical to reset. Engines are not notified; the integrator resets them with the same `rst`.
- **cycle_count:** increments once per cycle in CONV through DONE inclusive, then holds until the next accepted `start`. It saturates at all-ones.

## Timing
- If an engine asserts done D cycles after its start pulse, that stage occupies D+1 cycles.
- The next start pulse occurs in cycle t+D+1, where t is the current start-pulse cycle.
- Run latency from the `start` sample to the `done` pulse:
  - Training: 4·(D+1)+1 cycles.
  - Inference: 3·(D+1)+1 cycles.
- `cycle_count` on `done` equals that latency.
- Minimum stage length is 1 cycle, with done coincident with the start pulse.

## Configuration
- `SEQ_TIMEOUT_EN` defined: a per-stage counter is reset to 0 in each start-pulse cycle and increments every cycle the stage is active.
  - If the counter reaches `TIMEOUT_CYCLES`-1 without the stage done, the block goes to ERR next cycle and sets `error`=1; no further starts are issued.
  - A done arriving in the limit cycle wins; no error is raised.
  - ERR holds until `start` or `abort`.
- `SEQ_TIMEOUT_EN` undefined: no counter is built, `error` is tied 0, and ERR is unreachable.

## Structure
- Shared package `cnn_pkg`: `seq_state_t` enum with the stage encodings above, and `STAGE_W`=3.
- One sub-module, `seq_watchdog`, holding the counter and the limit compare. It is instantiated only under `SEQ_TIMEOUT_EN`.

## Test plan
- **Training run:** reset, then `start` with `train_mode`=1; each engine returns done 5 cycles after its start.
  - Expect the starts in order CONV, POOL, FC, LOSS, each exactly 1 cycle, spaced 6 cycles apart.
  - Expect `done` at cycle 25 and `cycle_count`=25.
- **Inference run:** `train_mode`=0, D=5.
  - Expect `loss_start` never asserted, `done` at cycle 19, `cycle_count`=19.
- **Stray and repeated events:** `fc_done` during CONV, `start` during POOL.
  - Expect no state change and no extra start pulses; the run completes normally.
- **Abort:** `abort` during FC.
  - Expect `stage`=0 and `busy`=0 next cycle, no `done` pulse, and `cycle_count` held.
  - A following `start` runs a full training run cleanly.
- **Zero-latency engines:** D=0 on all engines in training mode.
  - Expect start pulses on consecutive cycles and `done` at cycle 5.
- **Watchdog (`SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):** `pool_done` is never asserted.
  - Expect `error`=1 and `stage`=7 at 16 cycles after `pool_start`, and `fc_start` never asserted.
  - A following `start` clears `error`.
